// File: rtl/spiflash_bram_bridge.sv
// SPI flash read emulator: presents a 32-bit BRAM as a read-only SPI flash
// answering READ (0x03) and FAST READ (0x0B). All SPI pins are synchronised
// into ap_clk and edges are detected on the synchronised copies.
module spiflash_bram_bridge #(
  parameter int ADDR_BYTES   = 3,
  parameter int ROM_AW       = 14,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        csb,
  input  logic        spiclk,
  input  logic        io0,
  output logic        io1,
  output logic [31:0] romcode_Addr_A,
  output logic        romcode_EN_A,
  output logic [3:0]  romcode_WEN_A,
  output logic [31:0] romcode_Din_A,
  input  logic [31:0] romcode_Dout_A,
  output logic        romcode_Clk_A,
  output logic        romcode_Rst_A,
  output logic        busy,
  output logic [15:0] rd_bytes
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_DATA   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES * 8 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES);
  localparam logic [ROM_AW-1:0] ADDR_ONE  = {{(ROM_AW-1){1'b0}}, 1'b1};
  localparam logic [ROM_AW-1:0] WORD_MASK = {{(ROM_AW-2){1'b1}}, 2'b00};

  // Pick the addressed byte lane out of a little-endian BRAM word.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  // Word-aligned, zero-extended BRAM byte address for a ROM byte address.
  function automatic logic [31:0] word_addr(input logic [ROM_AW-1:0] a);
    logic [31:0] r;
    r = 32'd0;
    r[ROM_AW-1:0] = a & WORD_MASK;
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] io0_sync_q, io0_sync_d;
  logic        csb_prev_q, csb_prev_d;
  logic        sck_prev_q, sck_prev_d;
  logic [2:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [ROM_AW-2:0] shift_q, shift_d;
  logic        dummy_q, dummy_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        lat_q, lat_d;
  logic        io1_q, io1_d;
  logic        en_q, en_d;
  logic [31:0] addr_a_q, addr_a_d;
  logic        busy_q, busy_d;
  logic [15:0] rd_bytes_q, rd_bytes_d;

  logic csb_s, sck_s, io0_s;
  logic csb_rise, csb_fall, sck_rise, sck_fall;
  logic [ROM_AW-1:0] addr_full;
  logic [7:0] opcode;

  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign io0_s     = io0_sync_q[SYNC_STAGES-1];
  assign csb_rise  = csb_s & ~csb_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign addr_full = {shift_q, io0_s};
  assign opcode    = {shift_q[6:0], io0_s};

  assign io1            = io1_q;
  assign romcode_EN_A   = en_q;
  assign romcode_Addr_A = addr_a_q;
  assign romcode_WEN_A  = 4'd0;
  assign romcode_Din_A  = 32'd0;
  assign romcode_Clk_A  = ap_clk;
  assign romcode_Rst_A  = ap_rst;
  assign busy           = busy_q;
  assign rd_bytes       = rd_bytes_q;

  // Next-state logic: synchronisers, transaction FSM, BRAM fetch and MISO shifter.
  always_comb begin
    csb_sync_d = {csb_sync_q[SYNC_STAGES-2:0], csb};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spiclk};
    io0_sync_d = {io0_sync_q[SYNC_STAGES-2:0], io0};
    csb_prev_d = csb_s;
    sck_prev_d = sck_s;
    // After reset the chain holds reset values; a transaction may only start
    // once csb has been seen high with a fully refreshed chain.
    if (settle_q != SETTLE_MAX) settle_d = settle_q + 3'd1;
    else                        settle_d = settle_q;
    armed_d    = armed_q | ((settle_q == SETTLE_MAX) & csb_s);
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    dummy_d    = dummy_q;
    addr_d     = addr_q;
    io1_d      = io1_q;
    rd_bytes_d = rd_bytes_q;
    lat_d      = en_q;
    en_d       = 1'b0;
    addr_a_d   = addr_a_q;
    if (lat_q) tx_d = lane_byte(romcode_Dout_A, addr_q[1:0]);
    else       tx_d = tx_q;

    if (csb_rise) begin
      state_d = S_IDLE;
      io1_d   = 1'b0;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (csb_fall && armed_q) begin
            state_d = S_CMD;
            cnt_d   = 8'd0;
            shift_d = '0;
            dummy_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            shift_d = {shift_q[ROM_AW-3:0], io0_s};
            if (cnt_q == 8'd7) begin
              cnt_d   = 8'd0;
              shift_d = '0;
              case (opcode)
                8'h03:   begin state_d = S_ADDR;   dummy_d = 1'b0; end
                8'h0B:   begin state_d = S_ADDR;   dummy_d = 1'b1; end
                default: begin state_d = S_IGNORE; dummy_d = 1'b0; end
              endcase
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            shift_d = {shift_q[ROM_AW-3:0], io0_s};
            if (cnt_q == ADDR_LAST) begin
              cnt_d  = 8'd0;
              addr_d = addr_full;
              if (dummy_q) begin
                state_d = S_DUMMY;
              end else begin
                state_d  = S_DATA;
                en_d     = 1'b1;
                addr_a_d = word_addr(addr_full);
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d    = 8'd0;
              state_d  = S_DATA;
              en_d     = 1'b1;
              addr_a_d = word_addr(addr_q);
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DATA: begin
          if (sck_rise) begin
            if (cnt_q == 8'd7) begin
              // Byte complete: count it, advance (wrapping) and prefetch the next one.
              cnt_d    = 8'd0;
              addr_d   = addr_q + ADDR_ONE;
              en_d     = 1'b1;
              addr_a_d = word_addr(addr_q + ADDR_ONE);
              if (rd_bytes_q != 16'hFFFF) rd_bytes_d = rd_bytes_q + 16'd1;
              else                        rd_bytes_d = rd_bytes_q;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else if (sck_fall) begin
            io1_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end else begin
            io1_d = io1_q;
          end
        end
        S_IGNORE: begin
          io1_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          io1_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      csb_sync_q <= '1;
      sck_sync_q <= '0;
      io0_sync_q <= '0;
      csb_prev_q <= 1'b1;
      sck_prev_q <= 1'b0;
      settle_q   <= 3'd0;
      armed_q    <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      shift_q    <= '0;
      dummy_q    <= 1'b0;
      addr_q     <= '0;
      tx_q       <= 8'd0;
      lat_q      <= 1'b0;
      io1_q      <= 1'b0;
      en_q       <= 1'b0;
      addr_a_q   <= 32'd0;
      busy_q     <= 1'b0;
      rd_bytes_q <= 16'd0;
    end else begin
      csb_sync_q <= csb_sync_d;
      sck_sync_q <= sck_sync_d;
      io0_sync_q <= io0_sync_d;
      csb_prev_q <= csb_prev_d;
      sck_prev_q <= sck_prev_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      dummy_q    <= dummy_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      lat_q      <= lat_d;
      io1_q      <= io1_d;
      en_q       <= en_d;
      addr_a_q   <= addr_a_d;
      busy_q     <= busy_d;
      rd_bytes_q <= rd_bytes_d;
    end
  end

endmodule

// File: tb/tb_spiflash_bram_bridge.sv
// Directed testbench for spiflash_bram_bridge: a mode-0 SPI host drives
// transactions against a BRAM model with known contents.
module tb_spiflash_bram_bridge;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        csb;
  logic        spiclk;
  logic        io0;
  logic        io1;
  logic [31:0] romcode_Addr_A;
  logic        romcode_EN_A;
  logic [3:0]  romcode_WEN_A;
  logic [31:0] romcode_Din_A;
  logic [31:0] romcode_Dout_A;
  logic        romcode_Clk_A;
  logic        romcode_Rst_A;
  logic        busy;
  logic [15:0] rd_bytes;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int io1_hi = 0;
  logic [31:0] alog[$];
  logic [31:0] rom [0:4095];

  spiflash_bram_bridge dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .csb(csb), .spiclk(spiclk), .io0(io0), .io1(io1),
    .romcode_Addr_A(romcode_Addr_A), .romcode_EN_A(romcode_EN_A),
    .romcode_WEN_A(romcode_WEN_A), .romcode_Din_A(romcode_Din_A),
    .romcode_Dout_A(romcode_Dout_A), .romcode_Clk_A(romcode_Clk_A),
    .romcode_Rst_A(romcode_Rst_A), .busy(busy), .rd_bytes(rd_bytes)
  );

  always #5 ap_clk = ~ap_clk;

  // BRAM model plus monitors for read strobes, addresses and MISO activity.
  always @(posedge ap_clk) begin
    if (romcode_EN_A) begin
      romcode_Dout_A <= rom[romcode_Addr_A[13:2]];
      en_cnt <= en_cnt + 1;
      alog.push_back(romcode_Addr_A);
    end
    if (io1 === 1'b1) io1_hi <= io1_hi + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    io0 = b;
    tick(8);
    r = io1;
    spiclk = 1'b1;
    tick(8);
    spiclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(t[i], bit_v);
      r[i] = bit_v;
    end
  endtask

  task automatic cs_start();
    tick(1);
    csb = 1'b0;
    tick(8);
  endtask

  task automatic cs_end();
    tick(8);
    csb = 1'b1;
    tick(12);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick(3);
    ap_rst = 1'b0;
    tick(4);
  endtask

  // Sends opcode and 3 address bytes.
  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] r;
    spi_byte(op, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; csb = 1'b1; spiclk = 1'b0; io0 = 1'b0;
    tick(3);
    checks += 9;
    if (io1 !== 1'b0) begin errors++; $display("FAIL reset_io1 got %b want 0", io1); end
    if (romcode_EN_A !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", romcode_EN_A); end
    if (romcode_Addr_A !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", romcode_Addr_A); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (rd_bytes !== 16'h0) begin errors++; $display("FAIL reset_rd_bytes got %h want 0", rd_bytes); end
    if (romcode_WEN_A !== 4'h0) begin errors++; $display("FAIL reset_wen got %h want 0", romcode_WEN_A); end
    if (romcode_Din_A !== 32'h0) begin errors++; $display("FAIL reset_din got %h want 0", romcode_Din_A); end
    if (romcode_Rst_A !== 1'b1) begin errors++; $display("FAIL reset_rsta got %b want 1", romcode_Rst_A); end
    if (romcode_Clk_A !== ap_clk) begin errors++; $display("FAIL clka got %b want %b", romcode_Clk_A, ap_clk); end
    ap_rst = 1'b0;
    tick(4);
    checks++;
    if (romcode_Rst_A !== 1'b0) begin errors++; $display("FAIL rsta_release got %b want 0", romcode_Rst_A); end
  endtask

  task automatic test_read();
    logic [7:0] r;
    cs_start();
    send_hdr(8'h03, 24'h000001);
    spi_byte(8'h00, r);
    checks += 2;
    if (r !== 8'h22) begin errors++; $display("FAIL read_b0 got %h want 22", r); end
    if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got %b want 1", busy); end
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'h33) begin errors++; $display("FAIL read_b1 got %h want 33", r); end
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'h44) begin errors++; $display("FAIL read_b2 got %h want 44", r); end
    cs_end();
    checks += 2;
    if (rd_bytes !== 16'd3) begin errors++; $display("FAIL read_count got %0d want 3", rd_bytes); end
    if (busy !== 1'b0) begin errors++; $display("FAIL read_idle got %b want 0", busy); end
  endtask

  task automatic test_fast_read();
    logic [7:0] r;
    int en_base;
    do_reset();
    en_base = en_cnt;
    cs_start();
    send_hdr(8'h0B, 24'h000004);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'hAA) begin errors++; $display("FAIL fast_b0 got %h want aa", r); end
    cs_end();
    checks += 2;
    if (en_cnt - en_base != 2) begin errors++; $display("FAIL fast_en_pulses got %0d want 2", en_cnt - en_base); end
    if (rd_bytes !== 16'd1) begin errors++; $display("FAIL fast_count got %0d want 1", rd_bytes); end
  endtask

  task automatic test_wrap();
    logic [7:0] r;
    int n0;
    n0 = alog.size();
    cs_start();
    send_hdr(8'h03, 24'h003FFF);
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'h99) begin errors++; $display("FAIL wrap_last got %h want 99", r); end
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'h11) begin errors++; $display("FAIL wrap_first got %h want 11", r); end
    cs_end();
    checks++;
    if (alog.size() < n0 + 2) begin
      errors++; $display("FAIL wrap_fetches got %0d want >=2", alog.size() - n0);
    end else begin
      checks++;
      if (alog[n0] !== 32'h3FFC) begin errors++; $display("FAIL wrap_addr0 got %h want 3ffc", alog[n0]); end
      if (alog[n0+1] !== 32'h0000) begin errors++; $display("FAIL wrap_addr1 got %h want 0", alog[n0+1]); end
    end
  endtask

  task automatic test_ignore();
    logic [7:0] r;
    logic [7:0] acc;
    int en_base, hi_base, n;
    en_base = en_cnt;
    hi_base = io1_hi;
    acc = 8'h00;
    cs_start();
    spi_byte(8'h9F, r);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'hFF, r);
      acc = acc | r;
    end
    checks += 3;
    if (acc !== 8'h00) begin errors++; $display("FAIL ignore_rx got %h want 00", acc); end
    if (io1_hi != hi_base) begin errors++; $display("FAIL ignore_io1 got %0d high cycles want 0", io1_hi - hi_base); end
    if (en_cnt != en_base) begin errors++; $display("FAIL ignore_en got %0d want 0", en_cnt - en_base); end
    tick(8);
    csb = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge ap_clk);
      #1;
      n++;
      if (busy === 1'b0) break;
    end
    checks++;
    if (n < 1 || n > 3 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_busy_fall got %0d cycles want 1..3", n);
    end
    tick(12);
  endtask

  task automatic test_abort();
    logic [7:0] r;
    logic b;
    do_reset();
    cs_start();
    send_hdr(8'h03, 24'h000000);
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'h11) begin errors++; $display("FAIL abort_b0 got %h want 11", r); end
    for (int k = 0; k < 4; k++) spi_bit(1'b0, b);
    cs_end();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busy); end
    if (rd_bytes !== 16'd1) begin errors++; $display("FAIL abort_count got %0d want 1", rd_bytes); end
    cs_start();
    send_hdr(8'h03, 24'h000005);
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'hBB) begin errors++; $display("FAIL abort_next_b0 got %h want bb", r); end
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'hCC) begin errors++; $display("FAIL abort_next_b1 got %h want cc", r); end
    cs_end();
    checks++;
    if (rd_bytes !== 16'd3) begin errors++; $display("FAIL abort_next_count got %0d want 3", rd_bytes); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int en_base;
    cs_start();
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    ap_rst = 1'b1;
    tick(2);
    checks += 5;
    if (io1 !== 1'b0) begin errors++; $display("FAIL rmid_io1 got %b want 0", io1); end
    if (romcode_EN_A !== 1'b0) begin errors++; $display("FAIL rmid_en got %b want 0", romcode_EN_A); end
    if (romcode_Addr_A !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", romcode_Addr_A); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    if (rd_bytes !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", rd_bytes); end
    ap_rst = 1'b0;
    en_base = en_cnt;
    spi_byte(8'h01, r);
    spi_byte(8'h00, r);
    checks += 2;
    if (en_cnt != en_base) begin errors++; $display("FAIL rmid_no_en got %0d want 0", en_cnt - en_base); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_stay_idle got %b want 0", busy); end
    cs_end();
    cs_start();
    send_hdr(8'h03, 24'h000001);
    spi_byte(8'h00, r);
    checks++;
    if (r !== 8'h22) begin errors++; $display("FAIL rmid_next_b0 got %h want 22", r); end
    cs_end();
    checks++;
    if (rd_bytes !== 16'd1) begin errors++; $display("FAIL rmid_next_count got %0d want 1", rd_bytes); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
    rom[0]    = 32'h44332211;
    rom[1]    = 32'hDDCCBBAA;
    rom[4095] = 32'h99887766;
    romcode_Dout_A = 32'h0;
    ap_rst = 1'b1; csb = 1'b1; spiclk = 1'b0; io0 = 1'b0;
    test_reset();
    test_read();
    test_fast_read();
    test_wrap();
    test_ignore();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
